// File: rtl/pattern_sequencer.sv
// -----------------------------------------------------------------------------
// pattern_sequencer
//
// Clocked stimulus source. It holds a small pattern memory and zero-fills it
// after reset. On start it replays the first n stored patterns onto a
// WIDTH-bit bus, and holds each pattern for HOLD_CYCLES clocks.
//
// Ports
//   clk        in   1         single clock, rising edge
//   rst        in   1         synchronous, active-high reset
//   wr_en      in   1         pattern memory write strobe (IDLE / PLAY only)
//   wr_addr    in   ADDR_W    write address
//   wr_data    in   WIDTH     write data
//   start      in   1         begin replay (sampled in IDLE only)
//   num_pat    in   ADDR_W+1  patterns to replay; 0 ignored; >DEPTH clamps
//   abort      in   1         stop replay, return to IDLE
//   pat_out    out  WIDTH     current pattern
//   pat_valid  out  1         high while a pattern is being replayed
//   pat_last   out  1         high during the final pattern's hold window
//   busy       out  1         high in CLEAR or PLAY
//   clr_done   out  1         memory zero-fill complete
// -----------------------------------------------------------------------------
module pattern_sequencer #(
    parameter int WIDTH       = 6,
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 4,
    parameter int HOLD_CYCLES = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              start,
    input  logic [ADDR_W:0]   num_pat,
    input  logic              abort,
    output logic [WIDTH-1:0]  pat_out,
    output logic              pat_valid,
    output logic              pat_last,
    output logic              busy,
    output logic              clr_done
);

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_IDLE  = 2'd1,
        S_PLAY  = 2'd2
    } state_t;

    localparam int                HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [ADDR_W:0]   DEPTH_V   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    // Pattern memory. It has no reset; the CLEAR pass zero-fills it instead.
    logic [WIDTH-1:0] mem [DEPTH];

    state_t            state_reg;
    logic [ADDR_W-1:0] clr_addr_reg;
    logic [ADDR_W-1:0] idx_reg;        // index of the pattern now on pat_out
    logic [ADDR_W-1:0] last_idx_reg;   // n-1, latched at start
    logic [HOLD_W-1:0] hold_reg;
    logic [WIDTH-1:0]  pat_out_reg;
    logic              pat_valid_reg;
    logic              pat_last_reg;
    logic              busy_reg;
    logic              clr_done_reg;

    logic              start_ok;
    logic [ADDR_W:0]   n_clamped;
    logic [ADDR_W-1:0] n_last;
    logic [ADDR_W-1:0] idx_next;
    logic              hold_end;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WIDTH-1:0]  mem_wdata;

    assign start_ok  = (state_reg == S_IDLE) && start && (num_pat != '0);
    assign n_clamped = (num_pat > DEPTH_V) ? DEPTH_V : num_pat;
    assign n_last    = ADDR_W'(n_clamped - 1'b1);
    assign idx_next  = idx_reg + 1'b1;
    assign hold_end  = (hold_reg == HOLD_LAST);

    // Single write port. The clear pass owns it in CLEAR. Otherwise user
    // writes go through. Nothing is written while reset is held.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        if (!rst) begin
            if (state_reg == S_CLEAR) begin
                mem_we    = 1'b1;
                mem_waddr = clr_addr_reg;
                mem_wdata = '0;
            end else if (wr_en) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Control FSM with registered outputs. Loads read mem with non-blocking
    // semantics. A write to the address being loaded on the same edge
    // therefore yields the old word (read-before-write).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_CLEAR;
            clr_addr_reg  <= '0;
            idx_reg       <= '0;
            last_idx_reg  <= '0;
            hold_reg      <= '0;
            pat_out_reg   <= '0;
            pat_valid_reg <= 1'b0;
            pat_last_reg  <= 1'b0;
            busy_reg      <= 1'b1;
            clr_done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_CLEAR: begin
                    clr_addr_reg <= clr_addr_reg + 1'b1;
                    if (clr_addr_reg == ADDR_LAST) begin
                        state_reg    <= S_IDLE;
                        busy_reg     <= 1'b0;
                        clr_done_reg <= 1'b1;
                    end
                end

                S_IDLE: begin
                    if (start_ok) begin
                        state_reg     <= S_PLAY;
                        idx_reg       <= '0;
                        last_idx_reg  <= n_last;
                        hold_reg      <= '0;
                        pat_out_reg   <= mem[0];
                        pat_valid_reg <= 1'b1;
                        pat_last_reg  <= (n_last == '0);
                        busy_reg      <= 1'b1;
                    end
                end

                S_PLAY: begin
                    // abort wins over a pattern advance on the same edge.
                    if (abort || (hold_end && (idx_reg == last_idx_reg))) begin
                        state_reg     <= S_IDLE;
                        pat_valid_reg <= 1'b0;
                        pat_last_reg  <= 1'b0;
                        busy_reg      <= 1'b0;
                    end else if (hold_end) begin
                        idx_reg      <= idx_next;
                        hold_reg     <= '0;
                        pat_out_reg  <= mem[idx_next];
                        pat_last_reg <= (idx_next == last_idx_reg);
                    end else begin
                        hold_reg <= hold_reg + 1'b1;
                    end
                end

                default: begin
                    state_reg    <= S_CLEAR;
                    clr_addr_reg <= '0;
                    busy_reg     <= 1'b1;
                end
            endcase
        end
    end

    assign pat_out   = pat_out_reg;
    assign pat_valid = pat_valid_reg;
    assign pat_last  = pat_last_reg;
    assign busy      = busy_reg;
    assign clr_done  = clr_done_reg;

endmodule

// File: tb/tb_pattern_sequencer.sv
module tb_pattern_sequencer;

    localparam int WIDTH  = 6;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int HOLD   = 10;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic              start;
    logic [ADDR_W:0]   num_pat;
    logic              abort;
    logic [WIDTH-1:0]  pat_out;
    logic              pat_valid;
    logic              pat_last;
    logic              busy;
    logic              clr_done;

    pattern_sequencer #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .num_pat(num_pat), .abort(abort),
        .pat_out(pat_out), .pat_valid(pat_valid), .pat_last(pat_last),
        .busy(busy), .clr_done(clr_done)
    );

    always #5 clk = ~clk;

    // Observed output bundle: {pat_out, pat_valid, pat_last, busy, clr_done}
    typedef struct packed {
        logic [WIDTH-1:0] out;
        logic             valid;
        logic             last;
        logic             busy;
        logic             done;
    } obs_t;

    typedef struct {
        string           name;
        logic [ADDR_W:0] np;
        int              exp_n;
    } vec_t;

    obs_t             exp_q[$];
    logic [WIDTH-1:0] shadow [DEPTH];
    logic [WIDTH-1:0] model_out;
    int               checks = 0;
    int               errors = 0;

    function automatic obs_t mk(input logic [WIDTH-1:0] o, input logic v, input logic l,
                                input logic b, input logic d);
        obs_t r;
        r.out = o; r.valid = v; r.last = l; r.busy = b; r.done = d;
        return r;
    endfunction

    // One clock: the edge, then sample #1 later and compare with the scoreboard head.
    task automatic tick_check(input string name, input int cyc);
        obs_t a;
        obs_t e;
        @(posedge clk);
        #1;
        a = {pat_out, pat_valid, pat_last, busy, clr_done};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s cyc%0d: scoreboard empty, got %h", name, cyc, a);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                errors++;
                $display("FAIL %s cyc%0d: got out=%b v=%b l=%b busy=%b done=%b, exp out=%b v=%b l=%b busy=%b done=%b",
                         name, cyc, a.out, a.valid, a.last, a.busy, a.done,
                         e.out, e.valid, e.last, e.busy, e.done);
            end
        end
    endtask

    // Release reset and walk the 16-cycle zero-fill. Writes and start are
    // driven throughout and must be ignored.
    task automatic clear_seq(input string name);
        rst = 1'b0; wr_en = 1'b1; wr_addr = 4'd5; wr_data = 6'h3f;
        start = 1'b1; num_pat = 5'd4; abort = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            if (j < DEPTH - 1) exp_q.push_back(mk('0, 1'b0, 1'b0, 1'b1, 1'b0));
            else               exp_q.push_back(mk('0, 1'b0, 1'b0, 1'b0, 1'b1));
            tick_check(name, j);
        end
        wr_en = 1'b0; start = 1'b0;
        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
        model_out = '0;
        $display("clear %s: %0d cycles", name, DEPTH);
    endtask

    task automatic write_mem(input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        exp_q.push_back(mk(model_out, 1'b0, 1'b0, 1'b0, 1'b1));
        tick_check("write", int'(a));
        wr_en = 1'b0;
        shadow[a] = d;
        $display("write mem[%0d] = %b", a, d);
    endtask

    // Replay with start held high throughout; it must be ignored once
    // playing. The optional write, abort and reset land before tick wr_j,
    // abort_j and rst_j, where tick j is edge T+j.
    task automatic replay(input string name, input logic [ADDR_W:0] np, input int exp_n,
                          input int wr_j, input logic [ADDR_W-1:0] wa, input logic [WIDTH-1:0] wd,
                          input int abort_j, input int rst_j);
        logic [WIDTH-1:0] cur;
        int               total;
        obs_t             e;
        cur   = model_out;
        total = (exp_n == 0) ? 2 : exp_n * HOLD + 1;
        for (int j = 0; j < total; j++) begin
            start   = 1'b1;
            num_pat = np;
            wr_en   = (j == wr_j);
            wr_addr = wa;
            wr_data = wd;
            abort   = (j == abort_j);
            rst     = (j == rst_j);
            if (j == rst_j) begin
                e   = mk('0, 1'b0, 1'b0, 1'b1, 1'b0);
                cur = '0;
            end else if (exp_n == 0 || j == abort_j || j >= exp_n * HOLD) begin
                e = mk(cur, 1'b0, 1'b0, 1'b0, 1'b1);
            end else begin
                if (j % HOLD == 0) cur = shadow[j / HOLD];
                e = mk(cur, 1'b1, (j / HOLD) == exp_n - 1, 1'b1, 1'b1);
            end
            exp_q.push_back(e);
            if (j == wr_j && j != rst_j) shadow[wa] = wd;
            tick_check(name, j);
            if (j == abort_j || j == rst_j) break;
        end
        start = 1'b0; wr_en = 1'b0; abort = 1'b0; rst = 1'b0;
        model_out = cur;
        $display("replay %s: num_pat=%0d expect n=%0d, final pat_out=%b", name, np, exp_n, pat_out);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{"np4",  5'd4,  4};
        vecs[1] = '{"np0",  5'd0,  0};
        vecs[2] = '{"np1",  5'd1,  1};
        vecs[3] = '{"np16", 5'd16, 16};
        vecs[4] = '{"np20", 5'd20, 16};
        vecs[5] = '{"np31", 5'd31, 16};

        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; num_pat = '0; abort = 1'b0;
        model_out = '0;
        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;

        for (int j = 0; j < 2; j++) begin
            exp_q.push_back(mk('0, 1'b0, 1'b0, 1'b1, 1'b0));
            tick_check("reset", j);
        end
        clear_seq("power_on");

        write_mem(4'd0, 6'b011001);
        write_mem(4'd1, 6'b011011);
        write_mem(4'd2, 6'b011000);
        write_mem(4'd3, 6'b001000);
        for (int i = 4; i < DEPTH; i++) write_mem(ADDR_W'(i), WIDTH'(i * 5 + 7));

        for (int v = 0; v < 6; v++)
            replay(vecs[v].name, vecs[v].np, vecs[v].exp_n, -1, '0, '0, -1, -1);

        // abort at T+15, then a fresh replay starts again from mem[0]
        replay("abort", 5'd4, 4, -1, '0, '0, 15, -1);
        replay("after_abort", 5'd4, 4, -1, '0, '0, -1, -1);

        // write addr 1 on its load edge: old data now, new data next replay
        replay("wr_on_load", 5'd4, 4, 10, 4'd1, 6'b101010, -1, -1);
        replay("wr_new_seen", 5'd4, 4, -1, '0, '0, -1, -1);
        // write to a pattern not yet loaded shows up in the same replay
        replay("wr_ahead", 5'd4, 4, 5, 4'd3, 6'b010101, -1, -1);

        // reset at T+12 re-enters CLEAR; memory reads back all zero afterwards
        replay("rst_mid", 5'd4, 4, -1, '0, '0, -1, 12);
        clear_seq("after_rst");
        replay("zero_readback", 5'd16, 16, -1, '0, '0, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
        $fatal(1, "watchdog");
    end

endmodule
